// File: rtl/uart_rx_pkg.sv
// Shared definitions for the oversampling UART receiver: the receiver state
// encoding, the default data width and the 3-sample majority vote.
package uart_rx_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Majority of three line samples; rejects a single-sample disturbance.
    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_fsm.sv
// Frame sequencer for the UART receiver. Timing strobes (sample point, end
// of bit period, last data bit) and the voted bit value come from the top.
module uart_rx_fsm
    import uart_rx_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   rx_in,
    input  logic   par_en,
    input  logic   sample_pt,
    input  logic   bit_val,
    input  logic   bit_end,
    input  logic   last_bit,
    output state_t current_state
);

    // State register: walks start, data, optional parity and stop bit of each frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            current_state <= IDLE;
        end else begin
            case (current_state)
                IDLE: begin
                    if (!rx_in) current_state <= START;
                end
                START: begin
                    // A start bit that votes high was a glitch: abandon it at once.
                    if (sample_pt && bit_val) current_state <= IDLE;
                    else if (bit_end)         current_state <= DATA;
                end
                DATA: begin
                    if (bit_end && last_bit) current_state <= par_en ? PARITY : STOP;
                end
                PARITY: begin
                    if (bit_end) current_state <= STOP;
                end
                STOP: begin
                    // A low line at the end of the stop bit is taken as the next start.
                    if (bit_end) current_state <= rx_in ? IDLE : START;
                end
                default: current_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 1 start bit, DATA_W data bits LSB first,
// optional parity bit, 1 stop bit. The clock runs at prescale x baud.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               RX_IN,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    input  logic [PRESC_W-1:0] prescale,
    output logic [DATA_W-1:0]  P_DATA,
    output logic               par_err,
    output logic               stp_err,
    output logic               data_valid
);

    localparam int CNT_W = $clog2(DATA_W);

    state_t             current_state_s;
    logic [PRESC_W-1:0] edge_cnt_r;
    logic [CNT_W-1:0]   bit_cnt_r;
    logic [2:0]         samples_r;
    logic [PRESC_W-1:0] half_s;
    logic [PRESC_W-1:0] samp_lo_s;
    logic [PRESC_W-1:0] samp_hi_s;
    logic [PRESC_W-1:0] decide_s;
    logic [PRESC_W-1:0] last_edge_s;
    logic               sample_pt_s;
    logic               bit_end_s;
    logic               last_bit_s;
    logic               bit_val_s;
    logic               exp_par_s;

    // Decode sample positions from the live prescale and the voted bit value.
    always_comb begin
        half_s      = prescale >> 1;
        samp_lo_s   = half_s - PRESC_W'(1);
        samp_hi_s   = half_s + PRESC_W'(1);
        decide_s    = half_s + PRESC_W'(2);
        last_edge_s = prescale - PRESC_W'(1);
        sample_pt_s = (edge_cnt_r == decide_s);
        bit_end_s   = (edge_cnt_r == last_edge_s);
        last_bit_s  = (bit_cnt_r == CNT_W'(DATA_W - 1));
        bit_val_s   = maj3(samples_r);
        exp_par_s   = PAR_TYP ? ~^P_DATA : ^P_DATA;
    end

    // Position within the current bit period; the start-detect cycle counts as edge 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt_r <= {PRESC_W{1'b0}};
        end else if (current_state_s == IDLE) begin
            edge_cnt_r <= RX_IN ? {PRESC_W{1'b0}} : PRESC_W'(1);
        end else if ((current_state_s == START) && sample_pt_s && bit_val_s) begin
            edge_cnt_r <= {PRESC_W{1'b0}};
        end else if (bit_end_s) begin
            edge_cnt_r <= {PRESC_W{1'b0}};
        end else begin
            edge_cnt_r <= edge_cnt_r + PRESC_W'(1);
        end
    end

    // Index of the data bit currently being received; idle at 0 outside DATA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r <= {CNT_W{1'b0}};
        end else if (current_state_s != DATA) begin
            bit_cnt_r <= {CNT_W{1'b0}};
        end else if (bit_end_s) begin
            bit_cnt_r <= last_bit_s ? {CNT_W{1'b0}} : bit_cnt_r + CNT_W'(1);
        end
    end

    // Capture the line at the three edges straddling mid-bit for the majority vote.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samples_r <= 3'b000;
        end else if (current_state_s != IDLE) begin
            if (edge_cnt_r == samp_lo_s) samples_r[0] <= RX_IN;
            if (edge_cnt_r == half_s)    samples_r[1] <= RX_IN;
            if (edge_cnt_r == samp_hi_s) samples_r[2] <= RX_IN;
        end
    end

    // Deserialiser, parity/stop checks and the frame-good strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            P_DATA     <= {DATA_W{1'b0}};
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (current_state_s)
                START: begin
                    if (sample_pt_s && !bit_val_s) begin
                        par_err <= 1'b0;
                        stp_err <= 1'b0;
                    end
                end
                DATA: begin
                    if (sample_pt_s) P_DATA <= {bit_val_s, P_DATA[DATA_W-1:1]};
                end
                PARITY: begin
                    if (sample_pt_s) par_err <= (bit_val_s != exp_par_s);
                end
                STOP: begin
                    if (sample_pt_s) stp_err <= ~bit_val_s;
                    if (bit_end_s)   data_valid <= ~par_err & ~stp_err;
                end
                default: begin
                end
            endcase
        end
    end

    uart_rx_fsm u_fsm (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_in         (RX_IN),
        .par_en        (PAR_EN),
        .sample_pt     (sample_pt_s),
        .bit_val       (bit_val_s),
        .bit_end       (bit_end_s),
        .last_bit      (last_bit_s),
        .current_state (current_state_s)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are serialised from a byte-level
// model, good frames are queued, and a monitor checks every data_valid.
module tb_uart_rx;
    import uart_rx_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] prescale;
    logic [7:0] P_DATA;
    logic       par_err;
    logic       stp_err;
    logic       data_valid;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model_pdata;

    always #5 clk = ~clk;

    uart_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .prescale   (prescale),
        .P_DATA     (P_DATA),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .data_valid (data_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every data_valid must match the oldest outstanding good frame.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && data_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got data_valid with P_DATA %0h, expected no strobe", P_DATA);
            end else begin
                check("p_data_on_valid", {24'd0, P_DATA}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic send_bit(input logic b);
        RX_IN = b;
        repeat (prescale) @(negedge clk);
    endtask

    // Serialise one frame; bad_par flips the parity bit, stop_bit sets the stop level.
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic bad_par, input logic stop_bit);
        int   ones;
        logic pbit;
        logic exp_pe;
        logic exp_se;
        PAR_EN  = pe;
        PAR_TYP = pt;
        ones    = $countones(d);
        // Odd parity: total ones including parity bit is odd; even: total is even.
        pbit    = pt ? ((ones % 2) == 0) : ((ones % 2) == 1);
        pbit    = pbit ^ bad_par;
        exp_pe  = pe && bad_par;
        exp_se  = !stop_bit;
        if (!exp_pe && !exp_se) exp_q.push_back(d);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (pe) send_bit(pbit);
        send_bit(stop_bit);
        RX_IN = 1'b1;
        model_pdata = d;
        repeat (int'(prescale) + 4) @(negedge clk);
        check("par_err", {31'd0, par_err}, {31'd0, exp_pe});
        check("stp_err", {31'd0, stp_err}, {31'd0, exp_se});
        check("p_data_hold", {24'd0, P_DATA}, {24'd0, model_pdata});
        check("valid_pending", exp_q.size(), 0);
    endtask

    // One-clock low pulse on the line must be rejected as a false start.
    task automatic glitch(input logic [5:0] p);
        prescale = p;
        @(negedge clk);
        RX_IN = 1'b0;
        @(negedge clk);
        check("glitch_detected", {31'd0, dut.u_fsm.current_state == IDLE}, 32'd0);
        RX_IN = 1'b1;
        repeat (p) @(negedge clk);
        check("glitch_idle", {31'd0, dut.u_fsm.current_state == IDLE}, 32'd1);
        check("glitch_pdata", {24'd0, P_DATA}, {24'd0, model_pdata});
    endtask

    initial begin
        logic [5:0] presc_tab[3];
        presc_tab[0] = 6'd8;
        presc_tab[1] = 6'd16;
        presc_tab[2] = 6'd32;
        rst_n       = 1'b0;
        RX_IN       = 1'b1;
        PAR_EN      = 1'b0;
        PAR_TYP     = 1'b0;
        prescale    = 6'd8;
        model_pdata = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_p_data", {24'd0, P_DATA}, 32'd0);
        check("rst_flags", {29'd0, par_err, stp_err, data_valid}, 32'd0);
        check("rst_state", {31'd0, dut.u_fsm.current_state == IDLE}, 32'd1);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Directed frames: odd parity good, no parity, wrong parity, bad stop, recovery.
        prescale = 6'd8;
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1);
        prescale = 6'd16;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        prescale = 6'd8;
        send_frame(8'h81, 1'b1, 1'b0, 1'b1, 1'b1);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h6E, 1'b0, 1'b0, 1'b0, 1'b1);

        // Random bytes and parity settings at each legal prescale.
        for (int k = 0; k < 3; k++) begin
            prescale = presc_tab[k];
            for (int n = 0; n < 10; n++) begin
                send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), 1'b0, 1'b1);
            end
        end

        for (int k = 0; k < 3; k++) glitch(presc_tab[k]);

        // Reset in the middle of the data bits, then a clean frame.
        prescale = 6'd8;
        PAR_EN   = 1'b0;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        check("pre_rst_state", {31'd0, dut.u_fsm.current_state == DATA}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_p_data", {24'd0, P_DATA}, 32'd0);
        check("midrst_flags", {29'd0, par_err, stp_err, data_valid}, 32'd0);
        check("midrst_state", {31'd0, dut.u_fsm.current_state == IDLE}, 32'd1);
        @(negedge clk);
        RX_IN       = 1'b1;
        rst_n       = 1'b1;
        model_pdata = 8'h00;
        repeat (4) @(negedge clk);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1);

        repeat (20) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
